// File: rtl/eth_ram_frame_reader.sv
// Streams one frame out of a packet RAM: descriptor (addr, len) in, valid/ready words with last out.
// Optional frame counter port frame_cnt is enabled with `define ETH_FRAME_READER_STATS_EN.
module eth_ram_frame_reader #(
  parameter int unsigned DATAW  = 8,
  parameter int unsigned ADDRW  = 8,
  parameter int unsigned LENW   = 11,
  parameter int unsigned RD_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [ADDRW-1:0] desc_addr,
  input  logic [LENW-1:0]  desc_len,
  output logic [ADDRW-1:0] ram_raddr,
  input  logic [DATAW-1:0] ram_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DATAW-1:0] m_data,
  output logic             m_last,
  output logic             done,
`ifdef ETH_FRAME_READER_STATS_EN
  output logic [15:0]      frame_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ADDRW-1:0] rd_ptr;
  logic [LENW-1:0]  remaining;

  // Two-entry prefetch FIFO kept as head/tail registers so the head drives m_* directly
  logic             head_valid;
  logic             head_last;
  logic [DATAW-1:0] head_data;
  logic             tail_valid;
  logic             tail_last;
  logic [DATAW-1:0] tail_data;

  logic             head_valid_nxt;
  logic             head_last_nxt;
  logic [DATAW-1:0] head_data_nxt;
  logic             tail_valid_nxt;
  logic             tail_last_nxt;
  logic [DATAW-1:0] tail_data_nxt;

  logic             accept;
  logic             issue;
  logic             issue_last;
  logic             pop;
  logic             push;
  logic             push_last;
  logic [DATAW-1:0] push_data;
  logic             inflight;
  logic [2:0]       occ;

  assign m_valid    = head_valid;
  assign m_data     = head_data;
  assign m_last     = head_last;
  assign ram_raddr  = rd_ptr;
  assign pop        = head_valid & m_ready;
  assign accept     = desc_valid & desc_ready;
  assign issue_last = (remaining == LENW'(1));
  assign push_data  = ram_rdata;

  // Occupancy the FIFO would have after this cycle's pop, counting reads still in the RAM pipe
  assign occ = 3'(head_valid) + 3'(tail_valid) + 3'(inflight) - 3'(pop);

  // Capture path: comb RAM pushes in the issue cycle, registered RAM one cycle later
  if (RD_LAT == 0) begin : g_comb_rd
    assign push      = issue;
    assign push_last = issue_last;
    assign inflight  = 1'b0;
  end else begin : g_reg_rd
    logic issue_q;
    logic last_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        issue_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        issue_q <= issue;
        last_q  <= issue & issue_last;
      end
    end

    assign push      = issue_q;
    assign push_last = last_q;
    assign inflight  = issue_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && (desc_len != '0)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (occ < 3'd2) begin
          issue = 1'b1;
          if (issue_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO update: pop shifts tail into head, then push fills the first free slot
  always_comb begin
    head_valid_nxt = head_valid;
    head_last_nxt  = head_last;
    head_data_nxt  = head_data;
    tail_valid_nxt = tail_valid;
    tail_last_nxt  = tail_last;
    tail_data_nxt  = tail_data;
    if (pop) begin
      head_valid_nxt = tail_valid;
      head_last_nxt  = tail_last;
      head_data_nxt  = tail_data;
      tail_valid_nxt = 1'b0;
    end
    if (push) begin
      if (!head_valid_nxt) begin
        head_valid_nxt = 1'b1;
        head_last_nxt  = push_last;
        head_data_nxt  = push_data;
      end else begin
        tail_valid_nxt = 1'b1;
        tail_last_nxt  = push_last;
        tail_data_nxt  = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_last  <= 1'b0;
      head_data  <= '0;
      tail_valid <= 1'b0;
      tail_last  <= 1'b0;
      tail_data  <= '0;
    end else begin
      head_valid <= head_valid_nxt;
      head_last  <= head_last_nxt;
      head_data  <= head_data_nxt;
      tail_valid <= tail_valid_nxt;
      tail_last  <= tail_last_nxt;
      tail_data  <= tail_data_nxt;
    end
  end

  // Read pointer, word countdown and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      remaining  <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      desc_ready <= 1'b1;
    end else begin
      done       <= (accept && (desc_len == '0)) || (pop && head_last);
      busy       <= (state_nxt != S_IDLE);
      desc_ready <= (state_nxt == S_IDLE);
      if (accept) begin
        rd_ptr    <= desc_addr;
        remaining <= desc_len;
      end else if (issue) begin
        rd_ptr    <= rd_ptr + ADDRW'(1);
        remaining <= remaining - LENW'(1);
      end
    end
  end

`ifdef ETH_FRAME_READER_STATS_EN
  // Counts completed non-empty frames; wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst)                    frame_cnt <= '0;
    else if (pop && head_last)  frame_cnt <= frame_cnt + 16'(1);
  end
`endif

endmodule
